// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit placed between instruction fetch and the datapath.
// The opcode is decoded once, when the FSM leaves FETCH, into a registered
// control word. The FSM then runs the instruction through the states it needs.
// Each state waits for something different: user confirm for IN, disk ready
// for HD transfers (with a timeout), or a fixed number of cycles for the
// SET_PID syscall. EXEC is the only state that fires strobes and advances the
// PC. HALTED is left only by reset.
module unidade_controle_multiciclo #(
  parameter int OPCODE_W       = 6,
  parameter int OPALU_W        = 6,
  parameter int HD_TIMEOUT     = 255,
  parameter int SYSCALL_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                instr_valid,
  input  logic                io_ack,
  input  logic                hd_ready,
  output logic                OpIO,
  output logic                MemRead,
  output logic                AluSrc,
  output logic                RegDst,
  output logic                TypeJR,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                WriteHD,
  output logic                Desvio,
  output logic                Syscall_Sign,
  output logic [1:0]          Mem2Reg,
  output logic [OPALU_W-1:0]  OpALU,
  output logic                pc_en,
  output logic                busy,
  output logic                Halt,
  output logic                hd_timeout
);

  // One counter serves both WAIT_HD and SYSCALL, so it is sized for the
  // longer of the two waits.
  localparam int CNT_MAX = (HD_TIMEOUT > SYSCALL_CYCLES) ? HD_TIMEOUT : SYSCALL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HD_LAST  = CNT_W'(HD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYSCALL_CYCLES - 1);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    WAIT_IN = 3'd1,
    WAIT_HD = 3'd2,
    SYSCALL = 3'd3,
    EXEC    = 3'd4,
    HALTED  = 3'd5
  } state_t;

  // Datapath controls produced by decode. Level controls are held for the
  // whole instruction. Strobe controls are only released in EXEC.
  typedef struct packed {
    logic       op_io;
    logic       mem_read;
    logic       alu_src;
    logic       reg_dst;
    logic       type_jr;
    logic       reg_write;
    logic       mem_write;
    logic       write_hd;
    logic       desvio;
    logic [1:0] mem2reg;
  } ctrl_t;

  // Writeback select is ALU (2'b10) whenever no instruction is in flight.
  localparam ctrl_t CTRL_IDLE = '{mem2reg: 2'b10, default: 1'b0};

  // Opcode classes that leave FETCH for a state other than EXEC.
  localparam logic [OPCODE_W-1:0] OP_IN      = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_HALT    = OPCODE_W'(6'h19);
  localparam logic [OPCODE_W-1:0] OP_SET_PID = OPCODE_W'(6'h1C);
  localparam logic [OPCODE_W-1:0] OP_HD_WR   = OPCODE_W'(6'h1E);
  localparam logic [OPCODE_W-1:0] OP_HD_RD   = OPCODE_W'(6'h1F);

  function automatic ctrl_t decode_ctrl(input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = CTRL_IDLE;
    case (op)
      OPCODE_W'(6'h00), OPCODE_W'(6'h01), OPCODE_W'(6'h04), OPCODE_W'(6'h0D),
      OPCODE_W'(6'h0F), OPCODE_W'(6'h10), OPCODE_W'(6'h11), OPCODE_W'(6'h12): begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      OPCODE_W'(6'h02), OPCODE_W'(6'h03), OPCODE_W'(6'h14): begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OPCODE_W'(6'h05): begin
        c.desvio  = 1'b1;
        c.alu_src = 1'b1;
        c.reg_dst = 1'b1;
      end
      OPCODE_W'(6'h13): begin
        c.desvio  = 1'b1;
        c.alu_src = 1'b1;
        c.reg_dst = 1'b1;
        c.type_jr = 1'b1;
      end
      OPCODE_W'(6'h0A), OPCODE_W'(6'h0B): begin
        c.desvio = 1'b1;
      end
      OPCODE_W'(6'h06): begin
        c.alu_src   = 1'b1;
        c.mem_read  = 1'b1;
        c.reg_write = 1'b1;
        c.mem2reg   = 2'b00;
      end
      OPCODE_W'(6'h07): begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_IN: begin
        c.op_io     = 1'b1;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.mem2reg   = 2'b01;
      end
      OPCODE_W'(6'h09): begin
        c.op_io   = 1'b1;
        c.alu_src = 1'b1;
        c.mem2reg = 2'b01;
      end
      OP_SET_PID: begin
        c.alu_src  = 1'b1;
        c.mem_read = 1'b1;
        c.mem2reg  = 2'b00;
      end
      OP_HD_WR: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.write_hd  = 1'b1;
        c.mem2reg   = 2'b11;
      end
      OP_HD_RD: begin
        c.alu_src   = 1'b1;
        c.mem_read  = 1'b1;
        c.reg_write = 1'b1;
        c.mem2reg   = 2'b11;
      end
      default: c = CTRL_IDLE;  // nop, HALT and every unlisted opcode
    endcase
    return c;
  endfunction

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  ctrl_t             ctrl_q;
  logic [OPALU_W-1:0] opalu_q;
  logic              fetch_take;
  logic              hd_last;
  logic              sys_last;

  assign fetch_take = (state == FETCH) && instr_valid;
  assign hd_last    = (cnt == HD_LAST);
  assign sys_last   = (cnt == SYS_LAST);

  // State register and the shared wait counter, which restarts on every state change.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= '0;
      end else if (state == WAIT_HD || state == SYSCALL) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // Capture the decoded control word and ALU opcode as the instruction leaves FETCH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q  <= CTRL_IDLE;
      opalu_q <= '0;
    end else if (fetch_take) begin
      ctrl_q  <= decode_ctrl(Opcode);
      opalu_q <= OPALU_W'(Opcode);
    end
  end

  // Next-state logic. If hd_ready arrives in the expiry cycle, it wins over the timeout.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (instr_valid) begin
          if (Opcode == OP_IN)                              state_next = WAIT_IN;
          else if (Opcode == OP_HD_WR || Opcode == OP_HD_RD) state_next = WAIT_HD;
          else if (Opcode == OP_SET_PID)                    state_next = SYSCALL;
          else if (Opcode == OP_HALT)                       state_next = HALTED;
          else                                              state_next = EXEC;
        end
      end
      WAIT_IN: if (io_ack) state_next = EXEC;
      WAIT_HD: begin
        if (hd_ready)     state_next = EXEC;
        else if (hd_last) state_next = FETCH;
      end
      SYSCALL: if (sys_last) state_next = EXEC;
      EXEC:    state_next = FETCH;
      HALTED:  state_next = HALTED;
      default: state_next = FETCH;
    endcase
  end

  // Output decode: level controls while an instruction is in flight, strobes and PC enable only in EXEC.
  always_comb begin
    OpIO         = 1'b0;
    MemRead      = 1'b0;
    AluSrc       = 1'b0;
    RegDst       = 1'b0;
    TypeJR       = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    WriteHD      = 1'b0;
    Desvio       = 1'b0;
    Mem2Reg      = 2'b10;
    Syscall_Sign = 1'b0;
    pc_en        = 1'b0;
    hd_timeout   = 1'b0;
    busy         = (state != FETCH);
    Halt         = (state == WAIT_IN) || (state == HALTED);
    OpALU        = opalu_q;

    if (state != FETCH) begin
      OpIO    = ctrl_q.op_io;
      MemRead = ctrl_q.mem_read;
      AluSrc  = ctrl_q.alu_src;
      RegDst  = ctrl_q.reg_dst;
      TypeJR  = ctrl_q.type_jr;
      Mem2Reg = ctrl_q.mem2reg;
    end

    if (state == EXEC) begin
      RegWrite = ctrl_q.reg_write;
      MemWrite = ctrl_q.mem_write;
      WriteHD  = ctrl_q.write_hd;
      Desvio   = ctrl_q.desvio;
      pc_en    = 1'b1;
    end

    if (state == SYSCALL) Syscall_Sign = 1'b1;

    if (state == WAIT_HD && hd_last && !hd_ready) hd_timeout = 1'b1;
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multi-cycle control unit. It uses short HD timeout
// and syscall lengths so the wait paths finish in a few cycles.
module tb_unidade_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       instr_valid, io_ack, hd_ready;
  logic       OpIO, MemRead, AluSrc, RegDst, TypeJR;
  logic       RegWrite, MemWrite, WriteHD, Desvio, Syscall_Sign;
  logic [1:0] Mem2Reg;
  logic [5:0] OpALU;
  logic       pc_en, busy, Halt, hd_timeout;

  int passed = 0;
  int total  = 0;

  unidade_controle_multiciclo #(
    .OPCODE_W(6), .OPALU_W(6), .HD_TIMEOUT(4), .SYSCALL_CYCLES(3)
  ) dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .instr_valid(instr_valid),
    .io_ack(io_ack), .hd_ready(hd_ready), .OpIO(OpIO), .MemRead(MemRead),
    .AluSrc(AluSrc), .RegDst(RegDst), .TypeJR(TypeJR), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .WriteHD(WriteHD), .Desvio(Desvio),
    .Syscall_Sign(Syscall_Sign), .Mem2Reg(Mem2Reg), .OpALU(OpALU),
    .pc_en(pc_en), .busy(busy), .Halt(Halt), .hd_timeout(hd_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock edge and settle, so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Opcode = '0; instr_valid = 1'b0; io_ack = 1'b0; hd_ready = 1'b0;
    tick(); tick();
    total++; if ({busy, pc_en, Halt, hd_timeout, Syscall_Sign} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {busy, pc_en, Halt, hd_timeout, Syscall_Sign}); else passed++;
    total++; if ({Mem2Reg, OpALU} !== {2'b10, 6'h00}) $display("FAIL reset_mem2reg_opalu: got %b/%h want 10/00", Mem2Reg, OpALU); else passed++;
    total++; if ({OpIO, MemRead, AluSrc, RegDst, TypeJR, RegWrite, MemWrite, WriteHD, Desvio} !== 9'b0) $display("FAIL reset_ctrls: got %b want 0", {OpIO, MemRead, AluSrc, RegDst, TypeJR, RegWrite, MemWrite, WriteHD, Desvio}); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_plain();
    Opcode = 6'h00; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++; if ({RegDst, RegWrite, pc_en, busy, AluSrc} !== 5'b11110) $display("FAIL plain_exec: got %b want 11110", {RegDst, RegWrite, pc_en, busy, AluSrc}); else passed++;
    total++; if ({Mem2Reg, OpALU} !== {2'b10, 6'h00}) $display("FAIL plain_mem2reg: got %b/%h want 10/00", Mem2Reg, OpALU); else passed++;
    tick();
    total++; if ({busy, pc_en, RegWrite, RegDst} !== 4'b0) $display("FAIL plain_back_to_fetch: got %b want 0000", {busy, pc_en, RegWrite, RegDst}); else passed++;
    // Idle FETCH with instr_valid low must stay put.
    tick();
    total++; if ({busy, pc_en} !== 2'b00) $display("FAIL plain_idle: got %b want 00", {busy, pc_en}); else passed++;
  endtask

  task automatic test_in();
    // An acknowledge seen in FETCH must not shortcut the later wait.
    io_ack = 1'b1; tick();
    Opcode = 6'h08; instr_valid = 1'b1; io_ack = 1'b0;
    tick();
    instr_valid = 1'b0;
    total++; if ({Halt, busy, OpIO, AluSrc, pc_en, RegWrite} !== 6'b111100) $display("FAIL in_wait_entry: got %b want 111100", {Halt, busy, OpIO, AluSrc, pc_en, RegWrite}); else passed++;
    total++; if (Mem2Reg !== 2'b01) $display("FAIL in_mem2reg: got %b want 01", Mem2Reg); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({Halt, busy, pc_en, RegWrite} !== 4'b1100) $display("FAIL in_waiting[%0d]: got %b want 1100", i, {Halt, busy, pc_en, RegWrite}); else passed++;
    end
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    total++; if ({RegWrite, pc_en, Halt, busy, OpIO} !== 5'b11011) $display("FAIL in_exec: got %b want 11011", {RegWrite, pc_en, Halt, busy, OpIO}); else passed++;
    tick();
    total++; if ({busy, pc_en, Halt} !== 3'b000) $display("FAIL in_done: got %b want 000", {busy, pc_en, Halt}); else passed++;
  endtask

  task automatic test_hd_timeout();
    Opcode = 6'h1E; instr_valid = 1'b1; hd_ready = 1'b0;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if ({hd_timeout, busy, Mem2Reg} !== {(i == 3), 1'b1, 2'b11}) $display("FAIL hd_to_wait[%0d]: got %b want %b", i, {hd_timeout, busy, Mem2Reg}, {(i == 3), 1'b1, 2'b11}); else passed++;
      total++; if ({WriteHD, RegWrite, pc_en} !== 3'b000) $display("FAIL hd_to_strobes[%0d]: got %b want 000", i, {WriteHD, RegWrite, pc_en}); else passed++;
      tick();
    end
    total++; if ({busy, hd_timeout, WriteHD, RegWrite, pc_en} !== 5'b0) $display("FAIL hd_to_fetch: got %b want 00000", {busy, hd_timeout, WriteHD, RegWrite, pc_en}); else passed++;
  endtask

  task automatic test_hd_ready();
    // Disk ready in the second wait cycle.
    Opcode = 6'h1F; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    hd_ready = 1'b1;
    total++; if (hd_timeout !== 1'b0) $display("FAIL hd_rd_no_timeout: got %b want 0", hd_timeout); else passed++;
    tick();
    hd_ready = 1'b0;
    total++; if ({RegWrite, pc_en, MemRead, WriteHD, Mem2Reg} !== 6'b111011) $display("FAIL hd_rd_exec: got %b want 111011", {RegWrite, pc_en, MemRead, WriteHD, Mem2Reg}); else passed++;
    tick();
    // Disk ready lands in the very cycle the wait would expire.
    Opcode = 6'h1E; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick(); tick();
    hd_ready = 1'b1;
    #1;
    total++; if (hd_timeout !== 1'b0) $display("FAIL hd_coincide_no_pulse: got %b want 0", hd_timeout); else passed++;
    tick();
    hd_ready = 1'b0;
    total++; if ({WriteHD, RegWrite, pc_en} !== 3'b111) $display("FAIL hd_coincide_exec: got %b want 111", {WriteHD, RegWrite, pc_en}); else passed++;
    tick();
  endtask

  task automatic test_syscall();
    Opcode = 6'h1C; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if ({Syscall_Sign, MemRead, pc_en, busy} !== 4'b1101) $display("FAIL sys_hold[%0d]: got %b want 1101", i, {Syscall_Sign, MemRead, pc_en, busy}); else passed++;
      tick();
    end
    total++; if ({Syscall_Sign, MemRead, pc_en, RegWrite, Mem2Reg} !== 6'b011000) $display("FAIL sys_exec: got %b want 011000", {Syscall_Sign, MemRead, pc_en, RegWrite, Mem2Reg}); else passed++;
    tick();
    total++; if ({busy, MemRead, Syscall_Sign} !== 3'b000) $display("FAIL sys_done: got %b want 000", {busy, MemRead, Syscall_Sign}); else passed++;
  endtask

  task automatic test_back_to_back();
    Opcode = 6'h07; instr_valid = 1'b1;
    tick();
    Opcode = 6'h13;  // changes while in EXEC and must be ignored until FETCH
    total++; if ({MemWrite, AluSrc, RegWrite, pc_en, OpALU} !== {4'b1101, 6'h07}) $display("FAIL b2b_store: got %b want %b", {MemWrite, AluSrc, RegWrite, pc_en, OpALU}, {4'b1101, 6'h07}); else passed++;
    tick();
    total++; if ({busy, pc_en} !== 2'b00) $display("FAIL b2b_fetch: got %b want 00", {busy, pc_en}); else passed++;
    tick();
    Opcode = 6'h0C;
    total++; if ({Desvio, TypeJR, RegDst, AluSrc, RegWrite, pc_en, OpALU} !== {6'b111101, 6'h13}) $display("FAIL b2b_jr: got %b want %b", {Desvio, TypeJR, RegDst, AluSrc, RegWrite, pc_en, OpALU}, {6'b111101, 6'h13}); else passed++;
    tick(); tick();
    instr_valid = 1'b0;
    total++; if ({RegWrite, MemWrite, Desvio, AluSrc, pc_en, Mem2Reg} !== 7'b0000110) $display("FAIL b2b_nop: got %b want 0000110", {RegWrite, MemWrite, Desvio, AluSrc, pc_en, Mem2Reg}); else passed++;
    tick();
  endtask

  task automatic test_halt();
    Opcode = 6'h19; instr_valid = 1'b1;
    tick();
    total++; if ({Halt, busy, pc_en} !== 3'b110) $display("FAIL halt_entry: got %b want 110", {Halt, busy, pc_en}); else passed++;
    Opcode = 6'h00; io_ack = 1'b1; hd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({Halt, busy, pc_en, RegWrite} !== 4'b1100) $display("FAIL halt_sticky[%0d]: got %b want 1100", i, {Halt, busy, pc_en, RegWrite}); else passed++;
    end
    instr_valid = 1'b0; io_ack = 1'b0; hd_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++; if ({Halt, busy, pc_en, Mem2Reg, OpALU} !== {5'b00010, 6'h00}) $display("FAIL halt_reset: got %b want %b", {Halt, busy, pc_en, Mem2Reg, OpALU}, {5'b00010, 6'h00}); else passed++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_hd();
    Opcode = 6'h1E; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    total++; if ({busy, Mem2Reg} !== 3'b111) $display("FAIL midhd_waiting: got %b want 111", {busy, Mem2Reg}); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if ({busy, Mem2Reg, RegWrite, WriteHD, MemWrite, Desvio, pc_en, hd_timeout} !== 9'b010000000) $display("FAIL midhd_reset: got %b want 010000000", {busy, Mem2Reg, RegWrite, WriteHD, MemWrite, Desvio, pc_en, hd_timeout}); else passed++;
    tick();
    reset = 1'b0;
    tick(); tick();
    total++; if ({busy, hd_timeout} !== 2'b00) $display("FAIL midhd_stays_fetch: got %b want 00", {busy, hd_timeout}); else passed++;
  endtask

  initial begin
    test_reset();
    test_plain();
    test_in();
    test_hd_timeout();
    test_hd_ready();
    test_syscall();
    test_back_to_back();
    test_halt();
    test_reset_mid_hd();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
